// File: rtl/ring_router_vc.sv
// Two-virtual-channel bidirectional ring router: per-port, per-VC input FIFOs
// feed round-robin arbiters in front of registered cw/ccw/pe output stages.
module ring_router_vc #(
  parameter int unsigned PACKET_SIZE = 64,
  parameter int unsigned BUF_DEPTH   = 2,
  parameter int unsigned HOP_LSB     = 48,
  parameter int unsigned HOP_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   polarity,
  input  logic                   cwsi,
  input  logic                   ccwsi,
  input  logic                   pesi,
  output logic                   cwri,
  output logic                   ccwri,
  output logic                   peri,
  input  logic [PACKET_SIZE-1:0] cwd,
  input  logic [PACKET_SIZE-1:0] ccwd,
  input  logic [PACKET_SIZE-1:0] ped,
  output logic                   cwso,
  output logic                   ccwso,
  output logic                   peso,
  input  logic                   cwro,
  input  logic                   ccwro,
  input  logic                   pero,
  output logic [PACKET_SIZE-1:0] cwdo,
  output logic [PACKET_SIZE-1:0] ccwdo,
  output logic [PACKET_SIZE-1:0] pedo
);

  localparam int unsigned NPORT   = 3;
  localparam int unsigned PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNTW    = $clog2(BUF_DEPTH + 1);
  localparam int unsigned DIR_BIT = PACKET_SIZE - 2;

  // Index 0 = cw, 1 = ccw, 2 = pe for both sources and outputs
  logic [NPORT-1:0]              si, ri_c, ro, so_q, push, pop, load;
  logic [PACKET_SIZE-1:0]        din  [NPORT];
  logic [PACKET_SIZE-1:0]        head [NPORT];
  logic [PACKET_SIZE-1:0]        nxt  [NPORT];
  logic [PACKET_SIZE-1:0]        do_q [NPORT];
  logic [PACKET_SIZE-1:0]        mem  [NPORT][2][BUF_DEPTH];
  logic [PW-1:0]                 wr_ptr [NPORT][2];
  logic [PW-1:0]                 rd_ptr [NPORT][2];
  logic [CNTW-1:0]               cnt    [NPORT][2];
  logic [1:0]                    rr  [NPORT];
  logic [1:0]                    win [NPORT];
  logic [NPORT-1:0][NPORT-1:0]   req;
  logic                          ivc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] sum;
    sum = 3'(base) + 3'(k);
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  assign ivc     = ~polarity;
  assign si      = {pesi, ccwsi, cwsi};
  assign ro      = {pero, ccwro, cwro};
  assign din[0]  = cwd;
  assign din[1]  = ccwd;
  assign din[2]  = ped;
  assign push    = si & ri_c;
  assign {peri, ccwri, cwri} = ri_c;
  assign {peso, ccwso, cwso} = so_q;
  assign cwdo    = do_q[0];
  assign ccwdo   = do_q[1];
  assign pedo    = do_q[2];

  // Accept on the external VC whenever its FIFO has room
  always_comb begin
    ri_c = '0;
    for (int p = 0; p < NPORT; p++)
      ri_c[p] = !reset && (cnt[p][polarity] != CNTW'(BUF_DEPTH));
  end

  // Route each internal-VC head: hop exhausted ejects to pe, else follow dir
  always_comb begin
    req = '0;
    for (int p = 0; p < NPORT; p++) begin
      head[p] = mem[p][ivc][rd_ptr[p][ivc]];
      if (cnt[p][ivc] != '0) begin
        if (head[p][HOP_LSB +: HOP_WIDTH] == '0) req[2][p] = 1'b1;
        else if (head[p][DIR_BIT])               req[1][p] = 1'b1;
        else                                     req[0][p] = 1'b1;
      end
    end
  end

  // Round-robin pick per output; lowest offset from rr wins, so scan downwards
  always_comb begin
    load = '0;
    pop  = '0;
    for (int o = 0; o < NPORT; o++) begin
      win[o] = rr[o];
      for (int k = 2; k >= 0; k--)
        if (req[o][rr_idx(rr[o], 2'(k))]) win[o] = rr_idx(rr[o], 2'(k));
      load[o] = (!so_q[o] || ro[o]) && (req[o] != '0);
      if (load[o]) pop[win[o]] = 1'b1;
      nxt[o] = head[win[o]];
      if (o != 2) nxt[o][HOP_LSB +: HOP_WIDTH] = head[win[o]][HOP_LSB +: HOP_WIDTH] >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      so_q <= '0;
      for (int o = 0; o < NPORT; o++) begin
        do_q[o] <= '0;
        rr[o]   <= '0;
      end
      for (int p = 0; p < NPORT; p++) begin
        for (int v = 0; v < 2; v++) begin
          wr_ptr[p][v] <= '0;
          rd_ptr[p][v] <= '0;
          cnt[p][v]    <= '0;
        end
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (load[o]) begin
          so_q[o] <= 1'b1;
          do_q[o] <= nxt[o];
          rr[o]   <= (win[o] == 2'd2) ? 2'd0 : win[o] + 2'd1;
        end else if (ro[o]) begin
          so_q[o] <= 1'b0;
        end
      end
      // Push (external VC) and pop (internal VC) never target the same FIFO
      for (int p = 0; p < NPORT; p++) begin
        if (push[p]) begin
          wr_ptr[p][polarity] <= ptr_inc(wr_ptr[p][polarity]);
          cnt[p][polarity]    <= cnt[p][polarity] + CNTW'(1);
        end
        if (pop[p]) begin
          rd_ptr[p][ivc] <= ptr_inc(rd_ptr[p][ivc]);
          cnt[p][ivc]    <= cnt[p][ivc] - CNTW'(1);
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++)
      if (push[p]) mem[p][polarity][wr_ptr[p][polarity]] <= din[p];
  end

endmodule

// File: tb/tb_ring_router_vc.sv
// Scoreboard bench for ring_router_vc: expected packets queued per output at
// injection, popped and compared whenever an output transfers.
module tb_ring_router_vc;

  localparam int unsigned PS = 64;
  localparam int unsigned BD = 2;
  localparam int unsigned HL = 48;
  localparam int unsigned HW = 8;

  logic          clk = 1'b0;
  logic          reset, polarity;
  logic          cwsi, ccwsi, pesi, cwri, ccwri, peri;
  logic [PS-1:0] cwd, ccwd, ped;
  logic          cwso, ccwso, peso, cwro, ccwro, pero;
  logic [PS-1:0] cwdo, ccwdo, pedo;

  logic [PS-1:0] q_cw[$], q_ccw[$], q_pe[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_router_vc #(.PACKET_SIZE(PS), .BUF_DEPTH(BD), .HOP_LSB(HL), .HOP_WIDTH(HW)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
    .cwri(cwri), .ccwri(ccwri), .peri(peri),
    .cwd(cwd), .ccwd(ccwd), .ped(ped),
    .cwso(cwso), .ccwso(ccwso), .peso(peso),
    .cwro(cwro), .ccwro(ccwro), .pero(pero),
    .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
  );

  function automatic logic [PS-1:0] mk(input logic vc, input logic dir,
                                        input logic [HW-1:0] hop, input logic [31:0] pay);
    logic [PS-1:0] p;
    p = '0;
    p[PS-1] = vc;
    p[PS-2] = dir;
    p[HL +: HW] = hop;
    p[31:0] = pay;
    return p;
  endfunction

  function automatic int pending();
    return q_cw.size() + q_ccw.size() + q_pe.size();
  endfunction

  // One clock; polarity flips just after each edge like the global phase
  task automatic step();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic align(input logic pol);
    if (polarity !== pol) step();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && pending() != 0; k++) step();
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending exp 0", name, pending());
    end
  endtask

  task automatic monitor();
    logic [PS-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cwso && cwro) begin
          checks++;
          if (q_cw.size() == 0) begin
            errors++; $display("FAIL cw_unexpected got %h exp none", cwdo);
          end else begin
            e = q_cw.pop_front();
            if (cwdo !== e) begin errors++; $display("FAIL cw_data got %h exp %h", cwdo, e); end
          end
        end
        if (ccwso && ccwro) begin
          checks++;
          if (q_ccw.size() == 0) begin
            errors++; $display("FAIL ccw_unexpected got %h exp none", ccwdo);
          end else begin
            e = q_ccw.pop_front();
            if (ccwdo !== e) begin errors++; $display("FAIL ccw_data got %h exp %h", ccwdo, e); end
          end
        end
        if (peso && pero) begin
          checks++;
          if (q_pe.size() == 0) begin
            errors++; $display("FAIL pe_unexpected got %h exp none", pedo);
          end else begin
            e = q_pe.pop_front();
            if (pedo !== e) begin errors++; $display("FAIL pe_data got %h exp %h", pedo, e); end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cwsi = 1'b1;
    cwd = mk(1'b0, 1'b0, 8'h01, 32'h1111_1111);
    repeat (3) step();
    checks++;
    if ({cwri, ccwri, peri} !== 3'b000) begin
      errors++; $display("FAIL reset_ri got %b exp 000", {cwri, ccwri, peri});
    end
    checks++;
    if ({cwso, ccwso, peso} !== 3'b000) begin
      errors++; $display("FAIL reset_so got %b exp 000", {cwso, ccwso, peso});
    end
    checks++;
    if ((cwdo | ccwdo | pedo) !== '0) begin
      errors++; $display("FAIL reset_do got %h exp 0", cwdo | ccwdo | pedo);
    end
    cwsi = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({cwri, ccwri, peri} !== 3'b111) begin
      errors++; $display("FAIL release_ri got %b exp 111", {cwri, ccwri, peri});
    end
    step();
  endtask

  task automatic test_pe_to_cw();
    align(1'b0);
    ped = mk(1'b0, 1'b0, 8'h03, 32'hDEAD_BEEF);
    pesi = 1'b1;
    q_cw.push_back(mk(1'b0, 1'b0, 8'h01, 32'hDEAD_BEEF));
    #1;
    checks++;
    if (peri !== 1'b1) begin errors++; $display("FAIL pe2cw_ri got %b exp 1", peri); end
    step();
    pesi = 1'b0;
    checks++;
    if (cwso !== 1'b0) begin errors++; $display("FAIL pe2cw_early got %b exp 0", cwso); end
    step();
    checks++;
    if (cwso !== 1'b1) begin errors++; $display("FAIL pe2cw_so got %b exp 1", cwso); end
    checks++;
    if ({ccwso, peso} !== 2'b00) begin
      errors++; $display("FAIL pe2cw_other_so got %b exp 00", {ccwso, peso});
    end
    checks++;
    if (cwdo[HL +: HW] !== 8'h01) begin
      errors++; $display("FAIL pe2cw_hop got %h exp 01", cwdo[HL +: HW]);
    end
    drain("pe2cw");
  endtask

  task automatic test_ejection();
    logic [PS-1:0] p;
    p = mk(1'b0, 1'b0, 8'h00, 32'h1234_5678);
    align(1'b0);
    cwd = p;
    cwsi = 1'b1;
    q_pe.push_back(p);
    step();
    cwsi = 1'b0;
    step();
    checks++;
    if (peso !== 1'b1) begin errors++; $display("FAIL eject_so got %b exp 1", peso); end
    checks++;
    if (pedo !== p) begin errors++; $display("FAIL eject_do got %h exp %h", pedo, p); end
    checks++;
    if (cwso !== 1'b0) begin errors++; $display("FAIL eject_cwso got %b exp 0", cwso); end
    drain("eject");
  endtask

  task automatic test_contention();
    logic [PS-1:0] ecw, epe;
    ecw = mk(1'b0, 1'b0, 8'h01, 32'hAAAA_0001);
    epe = mk(1'b0, 1'b0, 8'h01, 32'hBBBB_0002);
    align(1'b0);
    cwd = mk(1'b0, 1'b0, 8'h02, 32'hAAAA_0001);
    ped = mk(1'b0, 1'b0, 8'h02, 32'hBBBB_0002);
    cwsi = 1'b1;
    pesi = 1'b1;
    q_cw.push_back(ecw);
    q_cw.push_back(epe);
    step();
    cwsi = 1'b0;
    pesi = 1'b0;
    step();
    checks++;
    if (cwso !== 1'b1 || cwdo !== ecw) begin
      errors++; $display("FAIL cont_first got so=%b %h exp so=1 %h", cwso, cwdo, ecw);
    end
    step();
    checks++;
    if (cwso !== 1'b0) begin errors++; $display("FAIL cont_gap got %b exp 0", cwso); end
    step();
    checks++;
    if (cwso !== 1'b1 || cwdo !== epe) begin
      errors++; $display("FAIL cont_second got so=%b %h exp so=1 %h", cwso, cwdo, epe);
    end
    drain("cont");
  endtask

  task automatic test_backpressure();
    logic [PS-1:0] p;
    logic          acc;
    align(1'b0);
    cwro = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p = mk(1'b0, 1'b0, 8'(8'hF0 + i), 32'hC0DE_0000 + 32'(i));
      cwd = p;
      cwsi = 1'b1;
      p[HL +: HW] = p[HL +: HW] >> 1;
      q_cw.push_back(p);
      #1;
      checks++;
      if (cwri !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b exp 1", i, cwri); end
      step();
    end
    p = mk(1'b0, 1'b0, 8'hF5, 32'hC0DE_0005);
    cwd = p;
    p[HL +: HW] = 8'h7A;
    q_cw.push_back(p);
    #1;
    checks++;
    if (cwri !== 1'b0) begin errors++; $display("FAIL bp_full_vc1 got %b exp 0", cwri); end
    checks++;
    if (cwso !== 1'b1 || cwdo !== mk(1'b0, 1'b0, 8'h78, 32'hC0DE_0000)) begin
      errors++; $display("FAIL bp_hold got so=%b %h", cwso, cwdo);
    end
    step();
    #1;
    checks++;
    if (cwri !== 1'b0) begin errors++; $display("FAIL bp_full_vc0 got %b exp 0", cwri); end
    cwro = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = cwri;
      step();
      #1;
    end
    cwsi = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL bp_sixth_accept got 0 exp 1"); end
    drain("bp");
  endtask

  task automatic test_async_reset();
    align(1'b0);
    cwro = 1'b0;
    ccwro = 1'b0;
    cwd = mk(1'b0, 1'b0, 8'h04, 32'h5A5A_0001);
    ped = mk(1'b0, 1'b1, 8'h04, 32'h5A5A_0002);
    cwsi = 1'b1;
    pesi = 1'b1;
    step();
    cwsi = 1'b0;
    ped = mk(1'b1, 1'b1, 8'h02, 32'h5A5A_0003);
    step();
    pesi = 1'b0;
    checks++;
    if (cwso !== 1'b1 || ccwso !== 1'b1) begin
      errors++; $display("FAIL arst_pre got %b%b exp 11", cwso, ccwso);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cwso, ccwso, peso} !== 3'b000) begin
      errors++; $display("FAIL arst_so got %b exp 000", {cwso, ccwso, peso});
    end
    checks++;
    if ((cwdo | ccwdo) !== '0) begin errors++; $display("FAIL arst_do got %h exp 0", cwdo | ccwdo); end
    step();
    step();
    reset = 1'b0;
    cwro = 1'b1;
    ccwro = 1'b1;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if ({cwso, ccwso, peso} !== 3'b000) begin
      errors++; $display("FAIL arst_stale got %b exp 000", {cwso, ccwso, peso});
    end
  endtask

  initial begin
    reset = 1'b1;
    polarity = 1'b0;
    {cwsi, ccwsi, pesi} = 3'b000;
    {cwro, ccwro, pero} = 3'b111;
    cwd = '0;
    ccwd = '0;
    ped = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_pe_to_cw();
    test_ejection();
    test_contention();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_router_vc.md
Name: ring_router_vc

Overview:
- Parametrised two-virtual-channel router for the bidirectional ring. It is the next generation of the single-buffer ring router.
- Ports: clockwise (cw), counter-clockwise (ccw) and processing-element (pe), each with one input and one output using a send/receive handshake.
- Each input has a BUF_DEPTH-deep FIFO per virtual channel (VC). Each output has a registered output stage.
- Routing uses a header direction bit and a right-shifting hop field. The global polarity signal alternates VCs between external (accepting) and internal (forwarding).

Parameters:
PACKET_SIZE, 64, packet width in bits; bit PACKET_SIZE-1 = VC, bit PACKET_SIZE-2 = dir (0 cw, 1 ccw)
BUF_DEPTH, 2, entries per input FIFO per VC (power of 2, >=1)
HOP_LSB, 48, LSB index of hop field
HOP_WIDTH, 8, hop field width; HOP_LSB+HOP_WIDTH <= PACKET_SIZE-2

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
polarity  in  1  global phase, toggles every cycle; external VC = polarity, internal VC = ~polarity
cwsi / ccwsi / pesi  in  1  upstream send (valid)
cwri / ccwri / peri  out  1  receive (ready) to upstream
cwd / ccwd / ped  in  PACKET_SIZE  input data
cwso / ccwso / peso  out  1  output send (valid)
cwro / ccwro / pero  in  1  downstream receive (ready)
cwdo / ccwdo / pedo  out  PACKET_SIZE  output data

Behaviour:
- Clock, reset: one clock (clk); reset is asynchronous and active-high.
- While reset is high:
  - all six FIFOs are empty; all FIFO pointers, counts and round-robin pointers are 0;
  - so = 0, do = 0 for every output; ri = 0 for every input.
- Input acceptance:
  - ri = !reset && FIFO[port][polarity] not full (combinational).
  - A transfer occurs at a rising edge with si && ri. The data is written to FIFO[port][polarity] unchanged; its VC bit is stored but not used for buffer selection.
- Routing of an internal-VC FIFO head (FIFO[port][~polarity]):
  - hop field == 0 -> pe output;
  - else dir = 0 -> cw output, dir = 1 -> ccw output.
  - The same rule applies to packets injected on the pe input.
- Output stage, one register per output:
  - holds packet + so flag;
  - a packet leaves at an edge with so && ro; do keeps its value after so drops.
- Load rule at each edge, per output:
  - the register is loaded if it is empty or is being emptied at that edge (so && ro), and at least one internal-VC head routes to it;
  - loaded content is the winner's head; so = 1 next cycle; the winner's FIFO pops.
- Hop update: packets loaded into cwdo/ccwdo have the hop field shifted right by 1 (zero-fill). Packets loaded into pedo are unmodified.
- Arbitration, per output:
  - round-robin over sources in order cw, ccw, pe;
  - a 2-bit pointer indicates the highest-priority source and moves to winner+1 (mod 3) after each grant; no change when there is no grant.
  - A head routes to exactly one output, so no source can win twice per edge.
- Latency: a packet accepted at edge N reaches its output register no earlier than the first edge after N where polarity equals the accepting VC's complement. With polarity toggling every cycle and no contention, so rises one cycle after acceptance.
- Full: while FIFO[port][polarity] holds BUF_DEPTH entries, ri = 0. Simultaneous push (external VC) and pop (internal VC) always hit different FIFOs.
- Backpressure: when ro = 0, the output holds so/do stable and the competing FIFO heads stay; no packet is lost or duplicated.
- Polarity stuck: if polarity is held constant, the external VC keeps filling and the internal VC keeps draining; there are no other side effects.
- Reset mid-operation: all buffered and output packets are discarded immediately (asynchronous); after deassertion, behaviour equals post-reset.

Test Plan:
- Reset/idle: assert reset for 3 cycles with cwsi = 1 -> cwri = ccwri = peri = 0, all so = 0, all do = 0; after release, ri = 1 for all inputs.
- Pe to cw: polarity toggling, ped = {VC=0, dir=0, hop=8'h03, payload 32'hDEADBEEF} at polarity = 0 -> one cycle later cwso = 1, cwdo hop = 8'h01, other fields unchanged; peso = ccwso = 0.
- Ejection: cwd with hop = 8'h00, payload 32'h12345678 -> pedo carries the identical packet, peso = 1 one cycle later.
- Contention: cwd and ped, both dir = 0 and hop = 8'h02, accepted the same cycle, cwro = 1 -> cwso carries the cw packet first and the pe packet 2 cycles later (next matching phase); round-robin pointer then favours ccw.
- Backpressure/full: BUF_DEPTH = 2, cwro = 0, stream 6 packets into cw, all dir = 0 -> output register + 2 entries per VC fill, then cwri = 0. Raise cwro -> all packets exit in order with hop fields each shifted once; none lost or duplicated.
- Async reset mid-flight: assert reset between edges while cwso = 1 -> cwso = 0 immediately; no stale packets appear after release.
